// File: rtl/rgmii_idelay_ctrl.sv
// Runtime tap controller for the RGMII RX IDELAYE2 lanes (rxd[3:0], rx_ctl = lane 4).
// Optional CNTVALUEOUT readback check after each load: define RGMII_IDELAY_VERIFY_EN.
module rgmii_idelay_ctrl #(
    parameter int unsigned LANES    = 5,
    parameter int unsigned TAP_W    = 5,
    parameter int unsigned INIT_TAP = 0,
    parameter int unsigned SETTLE   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   idelayctrl_rdy,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_lane,
    input  logic                   cfg_all,
    input  logic [TAP_W-1:0]       cfg_tap,
    output logic                   rsp_valid,
    output logic                   rsp_ok,
    output logic [LANES-1:0]       idelay_ld,
    output logic [LANES*TAP_W-1:0] idelay_cntvaluein,
    input  logic [LANES*TAP_W-1:0] idelay_cntvalueout,
    output logic                   init_done
);

    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [TAP_W-1:0] INIT_VAL  = TAP_W'(INIT_TAP);
    localparam logic [LANES-1:0] ALL_LANES = '1;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_LOAD,
        S_SETTLE,
        S_VERIFY,
        S_RESP,
        S_IDLE
    } state_t;

    state_t                   state;
    logic                     rdy_meta;
    logic                     rdy_sync;
    logic                     rdy_qual;
    logic [CNT_W-1:0]         settle_cnt;
    logic [LANES-1:0]         lane_mask;
    logic [LANES*TAP_W-1:0]   shadow;
    logic                     shadow_valid;
    logic                     init_pend;

    logic                     lane_in_range;
    logic [LANES-1:0]         cmd_mask;
    logic                     finish_now;
    logic                     finish_ok;

    assign idelay_cntvaluein = shadow;

    // Two-flop synchroniser for the asynchronous IDELAYCTRL RDY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
        end else begin
            rdy_meta <= idelayctrl_rdy;
            rdy_sync <= rdy_meta;
        end
    end

    // Command lane decode; broadcast overrides the lane index.
    always_comb begin
        lane_in_range = 32'(cfg_lane) < LANES;
        cmd_mask      = '0;
        if (cfg_all) begin
            cmd_mask = ALL_LANES;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (32'(cfg_lane) == 32'(i)) cmd_mask[i] = 1'b1;
            end
        end
    end

`ifdef RGMII_IDELAY_VERIFY_EN
    logic verify_ok;

    // Readback must match the shadow on every lane touched by the load.
    always_comb begin
        verify_ok = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (lane_mask[i] &&
                (idelay_cntvalueout[i*TAP_W +: TAP_W] != shadow[i*TAP_W +: TAP_W])) begin
                verify_ok = 1'b0;
            end
        end
    end

    assign finish_now = (state == S_VERIFY);
    assign finish_ok  = verify_ok;
`else
    logic unused_cntvalueout;

    assign unused_cntvalueout = ^idelay_cntvalueout;
    assign finish_now = (state == S_SETTLE) && (settle_cnt <= CNT_W'(1));
    assign finish_ok  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_WAIT_RDY;
            rdy_qual     <= 1'b0;
            settle_cnt   <= '0;
            lane_mask    <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            init_pend    <= 1'b0;
            cfg_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_ok       <= 1'b0;
            idelay_ld    <= '0;
            init_done    <= 1'b0;
        end else begin
            idelay_ld <= '0;
            rsp_valid <= 1'b0;

            if ((state != S_WAIT_RDY) && !rdy_sync) begin
                // Ready loss wins over everything; abort any user command with a failure.
                state     <= S_WAIT_RDY;
                rdy_qual  <= 1'b0;
                cfg_ready <= 1'b0;
                init_done <= 1'b0;
                init_pend <= 1'b0;
                if (!init_pend && (state inside {S_LOAD, S_SETTLE, S_VERIFY})) begin
                    rsp_valid <= 1'b1;
                    rsp_ok    <= 1'b0;
                end
            end else begin
                case (state)
                    S_WAIT_RDY: begin
                        if (!rdy_sync) begin
                            rdy_qual <= 1'b0;
                        end else if (!rdy_qual) begin
                            rdy_qual <= 1'b1;
                        end else begin
                            // Initial taps only on the first exit; re-entry replays retained shadows.
                            rdy_qual  <= 1'b0;
                            if (!shadow_valid) begin
                                shadow       <= {LANES{INIT_VAL}};
                                shadow_valid <= 1'b1;
                            end
                            lane_mask <= ALL_LANES;
                            idelay_ld <= ALL_LANES;
                            init_pend <= 1'b1;
                            state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        settle_cnt <= SETTLE_LD;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt > CNT_W'(1)) begin
                            settle_cnt <= settle_cnt - CNT_W'(1);
                        end else begin
`ifdef RGMII_IDELAY_VERIFY_EN
                            state <= S_VERIFY;
`endif
                        end
                    end
                    S_RESP: begin
                        cfg_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (cfg_valid) begin
                            cfg_ready <= 1'b0;
                            if (cfg_all || lane_in_range) begin
                                for (int i = 0; i < LANES; i++) begin
                                    if (cmd_mask[i]) shadow[i*TAP_W +: TAP_W] <= cfg_tap;
                                end
                                lane_mask <= cmd_mask;
                                idelay_ld <= cmd_mask;
                                state     <= S_LOAD;
                            end else begin
                                rsp_valid <= 1'b1;
                                rsp_ok    <= 1'b0;
                                state     <= S_RESP;
                            end
                        end
                    end
                    default: begin
                        state <= S_WAIT_RDY;
                    end
                endcase

                // Load sequence complete: init returns silently, user commands respond.
                if (finish_now) begin
                    if (init_pend) begin
                        init_pend <= 1'b0;
                        init_done <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_ok    <= finish_ok;
                        state     <= S_RESP;
                    end
                end
            end
        end
    end

endmodule
